// File: rtl/bcd_tick_countdown_if.sv
// ----------------------------------------------------------------------------
// bcd_tick_countdown_if
// Groups the control strobes and display/status outputs of the two-digit BCD
// countdown timer.
//   master : drives tick, load, load_value, start, pause; observes the outputs
//   slave  : the timer itself; consumes the controls, drives tens, ones,
//            hex1, hex0, running, done
// ----------------------------------------------------------------------------
interface bcd_tick_countdown_if;
    logic       tick;        // one-cycle decrement request
    logic       load;        // capture load_value as start/reload value
    logic [7:0] load_value;  // BCD {tens, ones}
    logic       start;       // begin countdown
    logic       pause;       // level; ticks ignored while high
    logic [3:0] tens;        // current tens digit
    logic [3:0] ones;        // current ones digit
    logic [6:0] hex1;        // active-low {g,f,e,d,c,b,a} for tens
    logic [6:0] hex0;        // active-low {g,f,e,d,c,b,a} for ones
    logic       running;     // high in RUN and PAUSE
    logic       done;        // DONE level, plus reload pulse when auto-reloading

    modport master (
        output tick, load, load_value, start, pause,
        input  tens, ones, hex1, hex0, running, done
    );

    modport slave (
        input  tick, load, load_value, start, pause,
        output tens, ones, hex1, hex0, running, done
    );
endinterface

// File: rtl/bcd_tick_countdown.sv
// ----------------------------------------------------------------------------
// bcd_tick_countdown
// Two-digit BCD countdown timer. Loads a (clamped) BCD start value, decrements
// once per accepted tick, and signals done on reaching 00. Optionally reloads
// the stored start value and keeps running (AUTO_RELOAD).
// Ports:
//   clk    : system clock, rising edge
//   resetn : asynchronous active-low reset
//   tmr    : slave side of bcd_tick_countdown_if (controls in, digits,
//            seven-segment codes, running and done out)
// ----------------------------------------------------------------------------
module bcd_tick_countdown #(
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic                  clk,
    input  logic                  resetn,
    bcd_tick_countdown_if.slave   tmr
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t     r_state;
    logic [3:0] r_tens;
    logic [3:0] r_ones;
    logic [3:0] r_rel_tens;
    logic [3:0] r_rel_ones;
    logic       r_running;
    logic       r_done;

    logic [3:0] w_ld_tens;
    logic [3:0] w_ld_ones;
    logic [3:0] w_dec_tens;
    logic [3:0] w_dec_ones;
    logic       w_is_zero;
    logic       w_is_one;
    logic       w_rel_zero;
    logic [6:0] w_hex1;
    logic [6:0] w_hex0;

    // A BCD digit above 9 is saturated to 9 rather than wrapped.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        logic [3:0] res;
        if (d > 4'd9) begin
            res = 4'd9;
        end else begin
            res = d;
        end
        return res;
    endfunction

    // Active-low seven-segment code {g,f,e,d,c,b,a}; non-BCD values blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    // Sanitised load value, BCD decrement and count comparisons.
    always_comb begin
        w_ld_tens  = clamp_digit(tmr.load_value[7:4]);
        w_ld_ones  = clamp_digit(tmr.load_value[3:0]);
        w_is_zero  = (r_tens == 4'd0) && (r_ones == 4'd0);
        w_is_one   = (r_tens == 4'd0) && (r_ones == 4'd1);
        w_rel_zero = (r_rel_tens == 4'd0) && (r_rel_ones == 4'd0);
        if (r_ones != 4'd0) begin
            w_dec_ones = r_ones - 4'd1;
            w_dec_tens = r_tens;
        end else begin
            w_dec_ones = 4'd9;
            w_dec_tens = r_tens - 4'd1;
        end
    end

    // Timer FSM: state, count, reload value, running and done all registered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_tens     <= 4'd0;
            r_ones     <= 4'd0;
            r_rel_tens <= 4'd0;
            r_rel_ones <= 4'd0;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            // done is a pulse unless a state below holds it as a level
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_running <= 1'b0;
                    if (tmr.load) begin
                        // load beats a simultaneous start
                        r_rel_tens <= w_ld_tens;
                        r_rel_ones <= w_ld_ones;
                        r_tens     <= w_ld_tens;
                        r_ones     <= w_ld_ones;
                    end else if (tmr.start) begin
                        if (w_is_zero) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= ST_RUN;
                            r_running <= 1'b1;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (tmr.pause) begin
                        r_state <= ST_PAUSE;
                    end else if (tmr.tick) begin
                        if (w_is_one) begin
                            if (AUTO_RELOAD && !w_rel_zero) begin
                                r_tens <= r_rel_tens;
                                r_ones <= r_rel_ones;
                                r_done <= 1'b1;
                            end else begin
                                r_tens    <= 4'd0;
                                r_ones    <= 4'd0;
                                r_state   <= ST_DONE;
                                r_running <= 1'b0;
                                r_done    <= 1'b1;
                            end
                        end else begin
                            r_tens <= w_dec_tens;
                            r_ones <= w_dec_ones;
                        end
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_PAUSE: begin
                    if (!tmr.pause) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_PAUSE;
                    end
                end
                ST_DONE: begin
                    r_running <= 1'b0;
                    if (tmr.load) begin
                        r_rel_tens <= w_ld_tens;
                        r_rel_ones <= w_ld_ones;
                        r_tens     <= w_ld_tens;
                        r_ones     <= w_ld_ones;
                        r_state    <= ST_IDLE;
                    end else if (tmr.start) begin
                        r_tens  <= r_rel_tens;
                        r_ones  <= r_rel_ones;
                        r_state <= ST_IDLE;
                    end else begin
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    // Display decode follows the registered digits combinationally.
    always_comb begin
        w_hex1 = seg_decode(r_tens);
        w_hex0 = seg_decode(r_ones);
    end

    assign tmr.tens    = r_tens;
    assign tmr.ones    = r_ones;
    assign tmr.hex1    = w_hex1;
    assign tmr.hex0    = w_hex0;
    assign tmr.running = r_running;
    assign tmr.done    = r_done;

endmodule

// File: tb/tb_bcd_tick_countdown.sv
// ----------------------------------------------------------------------------
// tb_bcd_tick_countdown
// Scoreboard bench: stimulus pushes hand-computed expected outputs into a
// queue; a monitor pops and compares them on the falling edge. Two DUTs:
// u_dut0 with AUTO_RELOAD=0, u_dut1 with AUTO_RELOAD=1.
// ----------------------------------------------------------------------------
module tb_bcd_tick_countdown;

    logic clk;
    logic resetn;

    bcd_tick_countdown_if if0 ();
    bcd_tick_countdown_if if1 ();

    bcd_tick_countdown #(.AUTO_RELOAD(1'b0)) u_dut0 (
        .clk    (clk),
        .resetn (resetn),
        .tmr    (if0.slave)
    );

    bcd_tick_countdown #(.AUTO_RELOAD(1'b1)) u_dut1 (
        .clk    (clk),
        .resetn (resetn),
        .tmr    (if1.slave)
    );

    typedef struct {
        int         sel;
        string      name;
        logic [3:0] tens;
        logic [3:0] ones;
        logic       running;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference seven-segment table, active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] ref_seg(input logic [3:0] d);
        logic [6:0] tbl [10];
        tbl[0] = 7'b1000000; tbl[1] = 7'b1111001; tbl[2] = 7'b0100100;
        tbl[3] = 7'b0110000; tbl[4] = 7'b0011001; tbl[5] = 7'b0010010;
        tbl[6] = 7'b0000010; tbl[7] = 7'b1111000; tbl[8] = 7'b0000000;
        tbl[9] = 7'b0010000;
        return (d <= 4'd9) ? tbl[d] : 7'b1111111;
    endfunction

    task automatic chk(input string nm, input string fld, input logic [6:0] got, input logic [6:0] want);
        n_checks++;
        if (got !== want) begin
            n_fails++;
            $display("FAIL %s.%s got %b expected %b", nm, fld, got, want);
        end
    endtask

    task automatic expect_out(input int sel, input string nm, input logic [7:0] bcd,
                              input logic run, input logic dn);
        exp_t e;
        e.sel = sel; e.name = nm; e.tens = bcd[7:4]; e.ones = bcd[3:0];
        e.running = run; e.done = dn;
        exp_q.push_back(e);
    endtask

    task automatic clear_inputs();
        if0.tick = 1'b0; if0.load = 1'b0; if0.load_value = 8'h00; if0.start = 1'b0; if0.pause = 1'b0;
        if1.tick = 1'b0; if1.load = 1'b0; if1.load_value = 8'h00; if1.start = 1'b0; if1.pause = 1'b0;
    endtask

    // Drive one cycle of inputs on one DUT, then queue the expected result.
    task automatic step(input int sel, input logic t, input logic l, input logic [7:0] lv,
                        input logic s, input logic p, input string nm,
                        input logic [7:0] ebcd, input logic erun, input logic edone);
        @(negedge clk);
        if (sel == 0) begin
            if0.tick = t; if0.load = l; if0.load_value = lv; if0.start = s; if0.pause = p;
        end else begin
            if1.tick = t; if1.load = l; if1.load_value = lv; if1.start = s; if1.pause = p;
        end
        @(posedge clk);
        #1;
        clear_inputs();
        expect_out(sel, nm, ebcd, erun, edone);
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
        end
    endtask

    // Monitor: compare every queued expectation against the selected DUT.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.sel == 0) begin
                    chk(e.name, "tens",    {3'd0, if0.tens},    {3'd0, e.tens});
                    chk(e.name, "ones",    {3'd0, if0.ones},    {3'd0, e.ones});
                    chk(e.name, "hex1",    if0.hex1,            ref_seg(e.tens));
                    chk(e.name, "hex0",    if0.hex0,            ref_seg(e.ones));
                    chk(e.name, "running", {6'd0, if0.running}, {6'd0, e.running});
                    chk(e.name, "done",    {6'd0, if0.done},    {6'd0, e.done});
                end else begin
                    chk(e.name, "tens",    {3'd0, if1.tens},    {3'd0, e.tens});
                    chk(e.name, "ones",    {3'd0, if1.ones},    {3'd0, e.ones});
                    chk(e.name, "hex1",    if1.hex1,            ref_seg(e.tens));
                    chk(e.name, "hex0",    if1.hex0,            ref_seg(e.ones));
                    chk(e.name, "running", {6'd0, if1.running}, {6'd0, e.running});
                    chk(e.name, "done",    {6'd0, if1.done},    {6'd0, e.done});
                end
            end
        end
    end

    // Stimulus
    initial begin
        logic [7:0] cnt12 [12];
        logic [7:0] from06 [6];
        logic [7:0] auto7 [7];
        logic       autod [7];
        cnt12 = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
        from06 = '{8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
        auto7 = '{8'h02, 8'h01, 8'h03, 8'h02, 8'h01, 8'h03, 8'h02};
        autod = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        clear_inputs();
        resetn = 1'b0;
        idle_cycles(3);
        @(posedge clk);
        #1;
        expect_out(0, "reset0", 8'h00, 1'b0, 1'b0);
        expect_out(1, "reset1", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        resetn = 1'b1;

        // Basic countdown from 12 with widely spaced ticks
        step(0, 1'b0, 1'b1, 8'h12, 1'b0, 1'b0, "load12", 8'h12, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "start12", 8'h12, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            idle_cycles(9);
            step(0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "cd12", cnt12[i],
                 (i == 11) ? 1'b0 : 1'b1, (i == 11) ? 1'b1 : 1'b0);
        end
        step(0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "tick13", 8'h00, 1'b0, 1'b1);

        // Pause and priority
        step(0, 1'b0, 1'b1, 8'h08, 1'b0, 1'b0, "load08_done", 8'h08, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "start08", 8'h08, 1'b1, 1'b0);
        step(0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "to07", 8'h07, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, "paused", 8'h07, 1'b1, 1'b0);
        end
        step(0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "release", 8'h07, 1'b1, 1'b0);
        step(0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "to06", 8'h06, 1'b1, 1'b0);
        step(0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, "load_in_run", 8'h06, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "cd06", from06[i],
                 (i == 5) ? 1'b0 : 1'b1, (i == 5) ? 1'b1 : 1'b0);
        end
        step(0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "start_in_done", 8'h08, 1'b0, 1'b0);
        step(0, 1'b0, 1'b1, 8'h05, 1'b1, 1'b0, "load_start", 8'h05, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "stay_idle", 8'h05, 1'b0, 1'b0);

        // Clamp and zero start
        step(0, 1'b0, 1'b1, 8'hAF, 1'b0, 1'b0, "clampAF", 8'h99, 1'b0, 1'b0);
        step(0, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b0, "clampA3", 8'h93, 1'b0, 1'b0);
        step(0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, "load00", 8'h00, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "start00", 8'h00, 1'b0, 1'b1);

        // Async reset in the middle of a count
        step(0, 1'b0, 1'b1, 8'h05, 1'b0, 1'b0, "load05", 8'h05, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "start05", 8'h05, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        expect_out(0, "async_rst", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;

        // Auto-reload from 03 with tick held high
        step(1, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, "a_load03", 8'h03, 1'b0, 1'b0);
        step(1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "a_start", 8'h03, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step(1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "a_tick", auto7[i], 1'b1, autod[i]);
        end
        step(1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "a_hold", 8'h02, 1'b1, 1'b0);

        idle_cycles(3);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL drain pending %0d expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
